// File: rtl/mem_io_responder.sv
// rtl/mem_io_responder.sv - byte-wide RAM plus UART/sim-end IO responder for the memory controller
module mem_io_responder #(
    parameter int RAM_ADDR_WIDTH = 17,
    parameter int TX_DEPTH       = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_addr,
    input  logic        mem_wr,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        sim_end,
    output logic        tx_overflow
);
    localparam int               PTR_W   = $clog2(TX_DEPTH);
    localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(TX_DEPTH);

    logic [7:0]       r_ram [0:(2**RAM_ADDR_WIDTH)-1];
    logic [7:0]       r_tx_mem [0:TX_DEPTH-1];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic [7:0]       r_rx_hold;
    logic             r_rx_valid;
    logic             r_sim_end;
    logic             r_tx_overflow;
    logic [7:0]       r_mem_dout;

    logic                      w_io;
    logic                      w_off_uart;
    logic                      w_off_end;
    logic [RAM_ADDR_WIDTH-1:0] w_ram_idx;
    logic                      w_push_req;
    logic                      w_pop;
    logic                      w_push;
    logic                      w_rx_cap;
    logic                      w_rx_rd;
    logic [7:0]                w_rd_data;
    logic                      w_unused;

    assign w_io       = (mem_addr[17:16] == 2'b11);
    assign w_off_uart = (mem_addr[2:0] == 3'd0);
    assign w_off_end  = (mem_addr[2:0] == 3'd4);
    assign w_ram_idx  = mem_addr[RAM_ADDR_WIDTH-1:0];
    assign w_unused   = &{1'b0, mem_addr[31:18]};

    assign tx_valid       = (r_count != '0);
    assign io_buffer_full = (r_count == DEPTH_C);
    assign tx_data        = tx_valid ? r_tx_mem[r_rd_ptr] : 8'h00;
    assign rx_ready       = !r_rx_valid;
    assign sim_end        = r_sim_end;
    assign tx_overflow    = r_tx_overflow;
    assign mem_dout       = r_mem_dout;

    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign w_push_req = w_io && w_off_uart && mem_wr;
    assign w_pop      = tx_valid && tx_ready;
    assign w_push     = w_push_req && ((r_count < DEPTH_C) || w_pop);
    assign w_rx_cap   = rx_valid && !r_rx_valid;
    assign w_rx_rd    = w_io && w_off_uart && !mem_wr;

    always_comb begin
        w_rd_data = 8'h00;
        if (!w_io)
            w_rd_data = r_ram[w_ram_idx];
        else if (w_off_uart && r_rx_valid)
            w_rd_data = r_rx_hold;
    end

    always_ff @(posedge clk) begin
        if (mem_wr && !w_io)
            r_ram[w_ram_idx] <= mem_din;
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_tx_mem[r_wr_ptr] <= mem_din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_rx_hold     <= 8'h00;
            r_rx_valid    <= 1'b0;
            r_sim_end     <= 1'b0;
            r_tx_overflow <= 1'b0;
            r_mem_dout    <= 8'h00;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_push_req && !w_push)
                r_tx_overflow <= 1'b1;
            if (mem_wr && w_io && w_off_end)
                r_sim_end <= 1'b1;
            if (!mem_wr)
                r_mem_dout <= w_rd_data;
            // Capture wins over a same-cycle read clear (which saw an empty holder).
            if (w_rx_cap) begin
                r_rx_hold  <= rx_data;
                r_rx_valid <= 1'b1;
            end else if (w_rx_rd) begin
                r_rx_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mem_io_responder.sv
// tb/tb_mem_io_responder.sv - directed self-checking bench for mem_io_responder
module tb_mem_io_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_addr;
    logic        mem_wr;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        sim_end;
    logic        tx_overflow;

    int checks   = 0;
    int failures = 0;

    mem_io_responder dut (
        .clk            (clk),
        .rst            (rst),
        .mem_addr       (mem_addr),
        .mem_wr         (mem_wr),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .io_buffer_full (io_buffer_full),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .sim_end        (sim_end),
        .tx_overflow    (tx_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic wr, input logic [31:0] addr, input logic [7:0] din);
        mem_wr   = wr;
        mem_addr = addr;
        mem_din  = din;
    endtask

    initial begin
        rst = 1'b1; mem_addr = 32'h0; mem_wr = 1'b0; mem_din = 8'h00;
        tx_ready = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
        #1;
        chk("rst_mem_dout", mem_dout, 8'h00);
        chk("rst_tx_valid", tx_valid, 1'b0);
        chk("rst_full", io_buffer_full, 1'b0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_rx_ready", rx_ready, 1'b1);
        chk("rst_sim_end", sim_end, 1'b0);
        chk("rst_overflow", tx_overflow, 1'b0);
        cyc(); cyc();
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h100 + i, 8'h11 * (i + 1));
            cyc();
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 32'h100 + i, 8'h00);
            cyc();
            chk($sformatf("ram_rd_%0d", i), mem_dout, 8'h11 * (i + 1));
        end

        drive(1'b1, 32'h20010, 8'hA5); cyc();
        drive(1'b0, 32'h00010, 8'h00); cyc();
        chk("alias_rd", mem_dout, 8'hA5);
        drive(1'b1, 32'h50, 8'h77); cyc();
        chk("dout_hold_on_wr", mem_dout, 8'hA5);

        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 32'h30000, 8'(i));
            cyc();
            chk($sformatf("fill_full_%0d", i), io_buffer_full, (i >= 7) ? 1'b1 : 1'b0);
            chk($sformatf("fill_ovf_%0d", i), tx_overflow, (i == 8) ? 1'b1 : 1'b0);
        end
        drive(1'b0, 32'h0, 8'h00);
        tx_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            chk($sformatf("drain_data_%0d", j), tx_data, 8'(j));
            cyc();
            if (j == 0) chk("full_falls", io_buffer_full, 1'b0);
        end
        chk("drain_empty", tx_valid, 1'b0);
        tx_ready = 1'b0;

        drive(1'b1, 32'h30000, 8'h99); cyc();
        drive(1'b1, 32'h30004, 8'h00); cyc();
        chk("sim_end_set", sim_end, 1'b1);
        chk("pre_rst_tx_valid", tx_valid, 1'b1);
        drive(1'b0, 32'h100, 8'h00); cyc();
        chk("pre_rst_dout", mem_dout, 8'h11);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_sim_end", sim_end, 1'b0);
        chk("arst_tx_valid", tx_valid, 1'b0);
        chk("arst_dout", mem_dout, 8'h00);
        chk("arst_overflow", tx_overflow, 1'b0);
        cyc();
        rst = 1'b0;
        drive(1'b0, 32'h103, 8'h00); cyc();
        chk("ram_persists", mem_dout, 8'h44);

        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'h30000, 8'hA0 + 8'(i));
            cyc();
        end
        chk("pp_full", io_buffer_full, 1'b1);
        tx_ready = 1'b1;
        drive(1'b1, 32'h30000, 8'h55);
        chk("pp_head", tx_data, 8'hA0);
        cyc();
        chk("pp_still_full", io_buffer_full, 1'b1);
        chk("pp_no_ovf", tx_overflow, 1'b0);
        drive(1'b0, 32'h0, 8'h00);
        for (int j = 0; j < 8; j++) begin
            chk($sformatf("pp_drain_%0d", j), tx_data, (j == 7) ? 8'h55 : 8'hA1 + 8'(j));
            cyc();
        end
        chk("pp_empty", tx_valid, 1'b0);
        tx_ready = 1'b0;

        rx_data = 8'h3C; rx_valid = 1'b1;
        drive(1'b0, 32'h101, 8'h00); cyc();
        rx_valid = 1'b0;
        chk("rx_ready_low", rx_ready, 1'b0);
        chk("rd_101", mem_dout, 8'h22);
        drive(1'b0, 32'h30000, 8'h00); cyc();
        chk("rx_rd", mem_dout, 8'h3C);
        chk("rx_ready_back", rx_ready, 1'b1);
        drive(1'b0, 32'h102, 8'h00); cyc();
        chk("rd_102", mem_dout, 8'h33);
        drive(1'b0, 32'h30000, 8'h00); cyc();
        chk("rx_rd_empty", mem_dout, 8'h00);
        drive(1'b0, 32'h103, 8'h00); cyc();
        drive(1'b0, 32'h30002, 8'h00); cyc();
        chk("io_other_rd", mem_dout, 8'h00);

        rx_data = 8'h5A; rx_valid = 1'b1;
        drive(1'b0, 32'h30000, 8'h00); cyc();
        rx_valid = 1'b0;
        chk("cap_clr_dout", mem_dout, 8'h00);
        chk("cap_clr_valid", rx_ready, 1'b0);
        cyc();
        chk("cap_clr_rd", mem_dout, 8'h5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
